// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control definitions: scheduler states and register-address constants.
// Also used by the forwarding unit.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        RUN         = 1'b0,
        MULDIV_WAIT = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/load_use_detector.sv
// Flags an ID instruction that reads the destination of a load still sitting in EX.
module load_use_detector
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] id_rs1_addr,
    input  logic [ADDR_W-1:0] id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [ADDR_W-1:0] ex_rd_addr,
    input  logic              ex_mem_read,
    output logic              hazard_c
);

    logic rs1_hit_c;
    logic rs2_hit_c;

    assign rs1_hit_c = id_rs1_used && (id_rs1_addr == ex_rd_addr);
    assign rs2_hit_c = id_rs2_used && (id_rs2_addr == ex_rd_addr);
    // x0 is hardwired, so a load targeting it never creates a dependency
    assign hazard_c  = ex_mem_read && (ex_rd_addr != ADDR_W'(ZERO_REG)) && (rs1_hit_c || rs2_hit_c);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Per-cycle advance/hold/bubble scheduler for the 5-stage pipeline, with
// saturating stall/flush counters and a data-memory timeout watchdog.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = pipeline_ctrl_pkg::REG_ADDR_W,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  ex_muldiv_op,
    input  logic                  muldiv_done,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  muldiv_start,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  id_ex_we,
    output logic                  ex_mem_we,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  mem_wb_bubble,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic                  mem_timeout_err
);

    localparam int unsigned WD_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             mem_timeout_err_q, mem_timeout_err_d;

    logic load_use_c;
    logic mem_stall_c;
    logic muldiv_stall_c;
    logic redirect_c;

    load_use_detector #(
        .ADDR_W (REG_ADDR_W)
    ) u_load_use (
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd_addr  (ex_rd_addr),
        .ex_mem_read (ex_mem_read),
        .hazard_c    (load_use_c)
    );

    assign mem_stall_c    = mem_req && !mem_ready;
    assign muldiv_stall_c = ((state_q == RUN) && ex_muldiv_op) ||
                            ((state_q == MULDIV_WAIT) && !muldiv_done);

    // Priority decode: memory freeze > mul/div hold > branch redirect > load-use
    always_comb begin
        state_d       = state_q;
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        id_ex_we      = 1'b1;
        ex_mem_we     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        muldiv_start  = 1'b0;
        redirect_c    = 1'b0;

        if (mem_stall_c) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (muldiv_stall_c) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_bubble = 1'b1;
            if (state_q == RUN) begin
                muldiv_start = 1'b1;
                state_d      = MULDIV_WAIT;
            end
        end else begin
            // Done cycle: the mul/div result advances like any other instruction
            if (state_q == MULDIV_WAIT) begin
                state_d = RUN;
            end
            if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                redirect_c   = 1'b1;
            end else if (load_use_c) begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end

        stall_cycles_d = stall_cycles_q;
        if (!pc_we && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        flush_count_d = flush_count_q;
        if (redirect_c && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end

        wd_cnt_d          = '0;
        mem_timeout_err_d = mem_timeout_err_q;
        if (mem_stall_c) begin
            wd_cnt_d = (wd_cnt_q == WD_W'(MEM_TIMEOUT)) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
            if (wd_cnt_d == WD_W'(MEM_TIMEOUT)) begin
                mem_timeout_err_d = 1'b1;
            end
        end

        // Hold every stage with a NOP in flight while in reset
        if (reset) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            mem_wb_bubble = 1'b1;
            muldiv_start  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= RUN;
            stall_cycles_q    <= '0;
            flush_count_q     <= '0;
            wd_cnt_q          <= '0;
            mem_timeout_err_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            stall_cycles_q    <= stall_cycles_d;
            flush_count_q     <= flush_count_d;
            wd_cnt_q          <= wd_cnt_d;
            mem_timeout_err_q <= mem_timeout_err_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign flush_count     = flush_count_q;
    assign mem_timeout_err = mem_timeout_err_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed hazard scenarios followed by
// random traffic, all checked every cycle against a behavioural model.
module tb_pipeline_stall_controller;

    localparam int unsigned AW      = 5;
    localparam int unsigned CW      = 8;
    localparam int unsigned TIMEOUT = 255;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken;
    logic          ex_muldiv_op, muldiv_done, mem_req, mem_ready;
    logic          muldiv_start, pc_we, if_id_we, id_ex_we, ex_mem_we;
    logic          if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
    logic [CW-1:0] stall_cycles, flush_count;
    logic          mem_timeout_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit       m_known = 1'b0;
    bit       m_busy;
    int       m_stall, m_flush, m_wd;
    bit       m_err;
    bit       f_mem, f_md, f_br;
    logic [8:0] exp_ctrl;

    pipeline_stall_controller #(
        .REG_ADDR_W  (AW),
        .CNT_W       (CW),
        .MEM_TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rd_addr      (ex_rd_addr),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv_op    (ex_muldiv_op),
        .muldiv_done     (muldiv_done),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .muldiv_start    (muldiv_start),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .id_ex_we        (id_ex_we),
        .ex_mem_we       (ex_mem_we),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_bubble   (ex_mem_bubble),
        .mem_wb_bubble   (mem_wb_bubble),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_timeout_err (mem_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Expected control vector {pc,ifid,idex,exmem, flush,idexb,exmemb,memwbb, start}
    task automatic model_eval();
        bit lu;
        f_mem = mem_req && !mem_ready;
        f_md  = m_busy ? !muldiv_done : ex_muldiv_op;
        lu    = ex_mem_read && (ex_rd_addr != 0) &&
                ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
                 (id_rs2_used && id_rs2_addr == ex_rd_addr));
        f_br  = 1'b0;
        if (reset)                exp_ctrl = 9'b0000_1111_0;
        else if (f_mem)           exp_ctrl = 9'b0000_0001_0;
        else if (f_md)            exp_ctrl = {8'b0001_0010, !m_busy};
        else if (ex_branch_taken) begin exp_ctrl = 9'b1111_1100_0; f_br = 1'b1; end
        else if (lu)              exp_ctrl = 9'b0011_0100_0;
        else                      exp_ctrl = 9'b1111_0000_0;
    endtask

    task automatic model_update();
        if (reset) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_stall = 0;
            m_flush = 0;
            m_wd    = 0;
            m_err   = 1'b0;
        end else begin
            if (!exp_ctrl[8] && m_stall < CNT_MAX) m_stall++;
            if (f_br && m_flush < CNT_MAX) m_flush++;
            if (f_mem) begin
                m_wd++;
                if (m_wd >= TIMEOUT) m_err = 1'b1;
            end else begin
                m_wd = 0;
            end
            if (!f_mem) m_busy = f_md;
        end
    endtask

    // One clock: check mid-cycle against the model, then advance the model at the edge
    task automatic tick();
        @(negedge clk);
        model_eval();
        chk("ctrl", {23'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush,
                     id_ex_bubble, ex_mem_bubble, mem_wb_bubble, muldiv_start}, {23'd0, exp_ctrl});
        if (m_known) begin
            chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
            chk("flush_count", 32'(flush_count), 32'(m_flush));
            chk("mem_timeout_err", 32'(mem_timeout_err), 32'(m_err));
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_muldiv_op = 1'b0; muldiv_done = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        do_reset();
        chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("rst_flush_count", 32'(flush_count), 32'd0);

        // Load x5, consumer reads x5 via rs2
        ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_rs2_used = 1'b1;
        tick();
        idle();
        tick();
        chk("load_use_stall_cycles", 32'(stall_cycles), 32'd1);

        // Load to x0 with rs1=x0 read
        ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs1_used = 1'b1;
        tick();
        idle();
        tick();
        chk("x0_no_stall", 32'(stall_cycles), 32'd1);

        // Branch taken together with a load-use hazard
        do_reset();
        ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_rs1_used = 1'b1;
        ex_branch_taken = 1'b1;
        tick();
        idle();
        tick();
        chk("branch_flush_count", 32'(flush_count), 32'd1);
        chk("branch_stall_cycles", 32'(stall_cycles), 32'd0);

        // Three not-ready memory cycles, ready on the fourth
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();
        idle();
        chk("mem_freeze_cycles", 32'(stall_cycles), 32'd3);

        // Mul/div with done four cycles after start
        do_reset();
        ex_muldiv_op = 1'b1;
        repeat (4) tick();
        muldiv_done = 1'b1;
        tick();
        idle();
        tick();
        chk("muldiv_stall_cycles", 32'(stall_cycles), 32'd4);

        // Reset during the wait, then a late done must be ignored
        ex_muldiv_op = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; ex_muldiv_op = 1'b0; muldiv_done = 1'b1;
        tick();
        muldiv_done = 1'b0;
        tick();
        chk("late_done_no_stall", 32'(stall_cycles), 32'd0);

        // Watchdog: 254 stalls stay clean, the 255th sets the sticky flag
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (TIMEOUT - 1) tick();
        chk("wd_below_timeout", 32'(mem_timeout_err), 32'd0);
        tick();
        chk("wd_at_timeout", 32'(mem_timeout_err), 32'd1);
        chk("stall_saturated", 32'(stall_cycles), 32'(CNT_MAX));
        mem_ready = 1'b1;
        repeat (3) tick();
        chk("wd_sticky", 32'(mem_timeout_err), 32'd1);
        idle();
        do_reset();
        chk("wd_cleared", 32'(mem_timeout_err), 32'd0);

        // Random traffic with a narrow register range so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            id_rs1_addr     = AW'($urandom_range(0, 3));
            id_rs2_addr     = AW'($urandom_range(0, 3));
            ex_rd_addr      = AW'($urandom_range(0, 3));
            id_rs1_used     = 1'($urandom_range(0, 1));
            id_rs2_used     = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            ex_muldiv_op    = ($urandom_range(0, 5) == 0);
            muldiv_done     = ($urandom_range(0, 3) == 0);
            mem_req         = 1'($urandom_range(0, 1));
            mem_ready       = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
